smartcargo_queue_scheduler: RTL
===============================

Name: smartcargo_queue_scheduler

Overview:
Upstream feeder of the SmartCargo 16-entry request queue RAM. Accepts one cargo request at a time (tipo, origem, destino) and scans the queued destinations through the RAM's secondary read ports. It then issues exactly one write command: fit (insert mid-queue) or weT (append at tail). It also tracks queue occupancy, since the RAM exposes no count.

Parameters:
DEPTH, 16, queue entries; must match RAM depth.
AW, 4, queue address width; log2(DEPTH).

Ports:
clk  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
req_valid  in  1  new request present
req_ready  out  1  scheduler can accept (state IDLE and count<DEPTH)
req_tipo  in  2  object type
req_origem  in  2  pickup floor
req_destino  in  2  drop floor
queue_shift  in  1  one-cycle pulse from downstream consumer when it pops head (RAM shift)
ram_dest_cur  in  2  RAM saidaSecundaria (entry at addr_sec, combinational read)
ram_dest_prev  in  2  RAM saidaSecundariaAnterior (entry at addr_sec_prev)
addr_sec  out  AW  secondary address to RAM (also fit insert position)
addr_sec_prev  out  AW  addr_sec-1 during scan, else 0
out_tipo / out_origem / out_destino  out  2 each  held request fields driven to RAM data inputs
we_top  out  1  one-cycle append strobe (RAM weT)
fit  out  1  one-cycle insert strobe (RAM fit)
count  out  AW+1  current occupancy 0..DEPTH
busy  out  1  state != IDLE

Behaviour:
- Reset (clear_n low, async): state IDLE, count=0, addr_sec=0, addr_sec_prev=0, out_* =0, we_top=0, fit=0, busy=0. A reset mid-scan abandons the request silently.
- FSM states IDLE, SCAN, COMMIT_FIT, COMMIT_APPEND.
- IDLE: on req_valid&&req_ready, latch fields into out_* and set k=1.
  - All-zero request (tipo=origem=destino=0) is indistinguishable from an empty RAM slot. It is accepted (handshake completes), dropped, no strobe, stays IDLE.
  - Else if count<=1 -> COMMIT_APPEND.
  - Else -> SCAN.
- SCAN: addr_sec=k, addr_sec_prev=k-1. One index per cycle.
  - Between test: (prev<origem<cur) or (prev>origem>cur), unsigned 2-bit compares on ram_dest_prev, req origem, ram_dest_cur.
  - Hit -> COMMIT_FIT with addr_sec held at k.
  - Miss with k==count-1 -> COMMIT_APPEND.
  - Otherwise k<=k+1.
- COMMIT_FIT: fit=1 for exactly one cycle with addr_sec=k and out_* stable. count<=count+1. Next state IDLE.
- COMMIT_APPEND: we_top=1 for exactly one cycle. count<=count+1. Next state IDLE.
- Strobes are never asserted together. Outside COMMIT_*, both are 0.
- Latency: accept at cycle T. Append with count<=1 strobes at T+1. A fit found at index k strobes at T+k+1. Worst case T+count.
- queue_shift:
  - count>0: count<=count-1.
  - count==0: ignored.
  - During SCAN: indices shift under the scan, so k restarts at 1 next cycle. If the decremented count<=1, go to COMMIT_APPEND instead.
  - In a COMMIT_* cycle: the strobe is suppressed combinationally that cycle and the FSM returns to SCAN with k=1. The request is not lost.
- Full: count==DEPTH forces req_ready=0. count never exceeds DEPTH or goes below 0.
- req_ready=0 whenever busy. Fields presented while not ready are ignored.

Optional Feature:
SCHED_STATS_EN
- Defined: adds outputs stat_fit[7:0] and stat_append[7:0]. Each is a saturating counter (stops at 255) incremented on each issued fit / we_top strobe. Suppressed strobes and dropped zero requests are not counted. Both reset to 0.
- Undefined: ports and logic absent. Behaviour otherwise identical.

Test Plan:
- Reset then single request (tipo=1, origem=2, destino=3) -> req_ready=1, we_top pulses at T+1, fit=0, count=1.
- Queue destinations [0,3] (count=2), request origem=1 destino=2 -> one SCAN cycle at addr_sec=1/addr_sec_prev=0, then fit=1 with addr_sec=1, count=3.
- Queue destinations [1,1,2] (count=3), request origem=3 -> SCAN k=1,2 both miss, then we_top pulse at T+3, count=4.
- Fill to count=16 -> req_ready=0, req_valid held high produces no strobe. One queue_shift -> count=15, req_ready=1 next cycle.
- queue_shift asserted in the COMMIT_FIT cycle -> fit stays 0 that cycle, count decrements, scan restarts at k=1, exactly one later fit or we_top is issued.
- All-zero request -> handshake completes, no strobe, count unchanged. clear_n pulsed mid-SCAN -> all outputs zero immediately.

Source files
------------

// File: rtl/smartcargo_queue_scheduler_if.sv
// SmartCargo request handshake between a request source and the scheduler.
// The master drives the request fields; the slave answers with req_ready.
interface smartcargo_queue_scheduler_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_tipo;
   logic [1:0] req_origem;
   logic [1:0] req_destino;

   modport master (
      output req_valid,
      output req_tipo,
      output req_origem,
      output req_destino,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_tipo,
      input  req_origem,
      input  req_destino,
      output req_ready
   );
endinterface

// File: rtl/smartcargo_queue_scheduler.sv
// SmartCargo queue scheduler: scans queued destinations, issues one fit/append.
// Optional SCHED_STATS_EN adds saturating fit/append strobe counters.
module smartcargo_queue_scheduler #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                 clk,
   input  logic                 clear_n,
   smartcargo_queue_scheduler_if.slave req,
   input  logic                 queue_shift,
   input  logic [1:0]           ram_dest_cur,
   input  logic [1:0]           ram_dest_prev,
   output logic [AW-1:0]        addr_sec,
   output logic [AW-1:0]        addr_sec_prev,
   output logic [1:0]           out_tipo,
   output logic [1:0]           out_origem,
   output logic [1:0]           out_destino,
   output logic                 we_top,
   output logic                 fit,
   output logic [AW:0]          count,
   output logic                 busy
`ifdef SCHED_STATS_EN
   ,
   output logic [7:0]           stat_fit,
   output logic [7:0]           stat_append
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT_FIT,
      COMMIT_APPEND
   } state_t;

   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] K_ONE = AW'(1);

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   k;
   logic [AW-1:0]   k_nxt;
   logic [AW:0]     cnt_nxt;
   logic [AW:0]     cnt_dec;
   logic [AW:0]     cnt_post;
   logic            accept;
   logic            zero_req;
   logic            shift_eff;
   logic            between;
   logic            last;

   assign req.req_ready = (state == IDLE) && (count < FULL);
   assign accept    = req.req_valid && req.req_ready;
   assign zero_req  = (req.req_tipo == 2'd0) && (req.req_origem == 2'd0)
                    && (req.req_destino == 2'd0);
   assign shift_eff = queue_shift && (count != '0);
   assign cnt_dec   = count - ONE;
   assign cnt_post  = shift_eff ? cnt_dec : count;
   assign between   = ((ram_dest_prev < out_origem) && (out_origem < ram_dest_cur))
                   || ((ram_dest_prev > out_origem) && (out_origem > ram_dest_cur));
   assign last      = ({1'b0, k} >= cnt_dec);

   assign busy          = (state != IDLE);
   assign addr_sec      = ((state == SCAN) || (state == COMMIT_FIT)) ? k : '0;
   assign addr_sec_prev = (state == SCAN) ? (k - K_ONE) : '0;

   // Next state, scan index and commit strobes; a pop during commit retries the scan.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      fit       = 1'b0;
      we_top    = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept && !zero_req) begin
               k_nxt     = K_ONE;
               state_nxt = (cnt_post <= ONE) ? COMMIT_APPEND : SCAN;
            end
         end
         SCAN: begin
            if (shift_eff) begin
               k_nxt     = K_ONE;
               state_nxt = (cnt_dec <= ONE) ? COMMIT_APPEND : SCAN;
            end else if (count <= ONE) begin
               state_nxt = COMMIT_APPEND;
            end else if (between) begin
               state_nxt = COMMIT_FIT;
            end else if (last) begin
               state_nxt = COMMIT_APPEND;
            end else begin
               k_nxt = k + K_ONE;
            end
         end
         COMMIT_FIT: begin
            if (shift_eff) begin
               k_nxt     = K_ONE;
               state_nxt = SCAN;
            end else begin
               fit       = 1'b1;
               state_nxt = IDLE;
            end
         end
         COMMIT_APPEND: begin
            if (shift_eff) begin
               k_nxt     = K_ONE;
               state_nxt = SCAN;
            end else begin
               we_top    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Occupancy: +1 per issued strobe, -1 per pop of a non-empty queue.
   always_comb begin
      cnt_nxt = count;
      if (fit || we_top) begin
         cnt_nxt = count + ONE;
      end else if (shift_eff) begin
         cnt_nxt = cnt_dec;
      end
   end

   // FSM, scan index and occupancy registers.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state <= IDLE;
         k     <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         count <= cnt_nxt;
      end
   end

   // Hold the accepted request fields on the RAM data inputs.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         out_tipo    <= '0;
         out_origem  <= '0;
         out_destino <= '0;
      end else if (accept) begin
         out_tipo    <= req.req_tipo;
         out_origem  <= req.req_origem;
         out_destino <= req.req_destino;
      end
   end

`ifdef SCHED_STATS_EN
   // Saturating counters of strobes actually issued to the RAM.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         stat_fit    <= '0;
         stat_append <= '0;
      end else begin
         if (fit && (stat_fit != 8'hFF)) begin
            stat_fit <= stat_fit + 8'd1;
         end
         if (we_top && (stat_append != 8'hFF)) begin
            stat_append <= stat_append + 8'd1;
         end
      end
   end
`endif

endmodule
